enable_seq_monitor: RTL
=======================

Name: enable_seq_monitor

Overview:
- Receiving end of the staggered-enable protocol emitted by the enable sequencer. The sequencer presents a thermometer-style enable vector that opens all gates, then drops them lowest-first back to zero.
- This block watches that vector, decodes the current stage and checks every transition against the legal sequence.
- It counts completed sequences and reports protocol errors (illegal pattern, skipped stage, stage timeout) to the controlling logic.
- It sits in the consuming clock domain; inputs arrive already synchronous to clk.

Parameters:
- STAGES, 4, number of enable lines monitored (ena_2..ena_5 map to ena_in[0..3]); range 2..7.
- TIMEOUT, 16, maximum consecutive evaluation edges a nonzero stage may hold; 0 disables the timeout check.
- CW, 8, width of the completed-sequence counter.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- ena_in  input  STAGES  enable vector under observation.
- clr_err  input  1  one-cycle request to leave the ERROR state.
- stage_o  output  3  decoded stage currently accepted (0..STAGES).
- busy  output  1  high while in ACTIVE.
- done  output  1  one-cycle pulse on a legal STAGES->0 transition.
- err  output  1  level; high while in ERROR.
- err_code  output  2  0 none, 1 illegal pattern, 2 skipped/backward stage, 3 timeout; held while in ERROR.
- seq_cnt  output  CW  completed sequences, modulo 2^CW.

Behaviour:
- Legal patterns:
  - stage 0 = all zeros.
  - stage k (1..STAGES) = ena_in[i]=1 for i>=k-1, all other bits 0.
  - With STAGES=4: 1111=1, 1110=2, 1100=3, 1000=4.
  - Any other value is illegal.
- Pipeline:
  - ena_in is registered into ena_q at edge E0.
  - At edge E1 the FSM evaluates decode(ena_q) against the stored stage.
  - All outputs are registered and update at E1.
  - Latency from an ena_in change to stage_o/done/err is 2 edges.
- Legal transitions, with s = stored stage and n = decoded stage:
  - n==s (hold).
  - s==0 -> n==1.
  - s in 1..STAGES-1 -> n==s+1.
  - s==STAGES -> n==0; this transition raises done and increments seq_cnt.
- Error priority when several apply on the same edge: illegal pattern (1) > bad transition (2) > timeout (3).
- Dwell counter:
  - Counts consecutive evaluation edges with the same nonzero stage; the entry edge counts as 1.
  - Cleared on any stage change and in stage 0.
  - The evaluation edge that would make the count TIMEOUT+1 flags timeout.
- States:
  - IDLE: stage 0. Pattern 1 -> ACTIVE. Hold 0 -> stay. Anything else -> ERROR.
  - ACTIVE: legal step -> stay or advance. Legal STAGES->0 -> IDLE, done=1, seq_cnt+1. Any error -> ERROR.
  - ERROR: err=1; err_code and stage_o frozen at values from the failing edge; ena_q ignored. clr_err -> RESYNC.
  - RESYNC: err=0, err_code=0, stage_o=0. Waits for decode(ena_q)==0, then -> IDLE. No done or count in this state; errors not reported.
- clr_err outside ERROR is ignored.
- busy is high only in ACTIVE.
- seq_cnt wraps from 2^CW-1 to 0 silently.
- Reset at any time, including mid-sequence, takes effect on the next edge:
  - State -> IDLE.
  - ena_q, stage_o, dwell, seq_cnt, err_code -> 0.
  - busy, done, err -> 0.
  - The first evaluation after reset compares against stage 0, so resuming mid-sequence (e.g. 1100) is a bad-transition error.

Decomposition:
- Package enable_seq_pkg holds:
  - state enum {IDLE, ACTIVE, ERROR, RESYNC}.
  - err_code constants ERR_NONE/ERR_ILLEGAL/ERR_SKIP/ERR_TIMEOUT.
  - A function returning the legal pattern for stage k.
- One sub-module, enable_stage_decoder: combinational; ena_q -> stage (3b) plus a legal flag. This lets the decode be unit-tested standalone.
- FSM, dwell counter and seq_cnt live in the top module.

Test Plan:
1. STAGES=4. Drive ena_in 0000,1111,1110,1100,1000,0000, one cycle each -> stage_o 0,1,2,3,4,0 (2-edge lag), done single pulse 2 edges after 0000, seq_cnt 0->1, err never asserted.
2. Drive 1111 then 1100 -> err=1, err_code=2, stage_o held at 1, busy=0; further ena_in changes produce no change.
3. From idle drive 0101 -> err_code=1. Separately drive 1111 then 0110 (illegal and non-adjacent) -> err_code=1, confirming priority.
4. TIMEOUT=16: drive 1111 one cycle, then hold 1110 for 20 cycles -> err_code=3 on the 17th evaluation edge of stage 2. Holding exactly 16 cycles then stepping to 1100 -> no error.
5. In ERROR with ena_in=1000, pulse clr_err -> RESYNC, err=0. Drive 0000 -> IDLE with no done and seq_cnt unchanged. The next full legal sequence -> done, seq_cnt+1.
6. CW=2: run 4 legal sequences -> seq_cnt 1,2,3,0. Assert rst while stage_o=3 -> all outputs 0 on the next edge. Then drive 1100 -> err_code=2.

Source files
------------

// File: rtl/enable_seq_pkg.sv
// rtl/enable_seq_pkg.sv - shared types, error codes and pattern helper for the enable sequence monitor
// Purpose: FSM state encoding, err_code values and the legal enable pattern
//          for each stage, shared by the top and the stage decoder.
// Ports:   none (package).
package enable_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2,
        RESYNC = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_SKIP    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Stage k keeps enables k-1 and above open; stage 0 is all gates closed.
    // The result is right-aligned in 8 bits; callers truncate to their width.
    function automatic logic [7:0] stage_pattern(input int stages, input int k);
        logic [7:0] mask;
        mask = 8'hFF >> (8 - stages);
        if (k == 0) begin
            return 8'h00;
        end
        return (8'hFF << (k - 1)) & mask;
    endfunction

endpackage

// File: rtl/enable_seq_monitor_if.sv
// rtl/enable_seq_monitor_if.sv - observed enable vector plus monitor status bundle
// Purpose: groups the monitored enable vector, the error-clear request and
//          all status outputs of enable_seq_monitor.
// Ports:   ena_in, clr_err (driven by master); stage_o, busy, done, err,
//          err_code, seq_cnt (driven by slave, the monitor).
interface enable_seq_monitor_if #(
    parameter int STAGES = 4,
    parameter int CW     = 8
);
    logic [STAGES-1:0] ena_in;
    logic              clr_err;
    logic [2:0]        stage_o;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [CW-1:0]     seq_cnt;

    modport master (
        output ena_in, clr_err,
        input  stage_o, busy, done, err, err_code, seq_cnt
    );

    modport slave (
        input  ena_in, clr_err,
        output stage_o, busy, done, err, err_code, seq_cnt
    );
endinterface

// File: rtl/enable_stage_decoder.sv
// rtl/enable_stage_decoder.sv - combinational enable-vector to stage decoder
// Purpose: maps a registered enable vector to its stage number and flags
//          vectors that match no legal stage pattern.
// Ports:   ena (in, STAGES) vector; stage (out, 3) decoded stage, 0 when
//          illegal; legal (out, 1) vector matches a stage pattern.
module enable_stage_decoder
    import enable_seq_pkg::*;
#(
    parameter int STAGES = 4
) (
    input  logic [STAGES-1:0] ena,
    output logic [2:0]        stage,
    output logic              legal
);

    always_comb begin
        stage = 3'd0;
        legal = 1'b0;
        for (int k = 0; k <= STAGES; k++) begin
            if (ena == STAGES'(stage_pattern(STAGES, k))) begin
                stage = 3'(k);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enable_seq_monitor.sv
// rtl/enable_seq_monitor.sv - staggered-enable protocol checker and sequence counter
// Purpose: registers the enable vector, checks each decoded stage against the
//          stored stage, counts completed open/close sequences and latches
//          protocol errors until cleared.
// Ports:   clk, rst (sync, active high); bus (slave modport): ena_in, clr_err
//          in; stage_o, busy, done, err, err_code, seq_cnt out.
module enable_seq_monitor
    import enable_seq_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int TIMEOUT = 16,
    parameter int CW      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    enable_seq_monitor_if.slave   bus
);

    // Dwell must be able to reach TIMEOUT; it saturates so a disabled
    // timeout never wraps into a false match.
    localparam int             DW          = $clog2(TIMEOUT + 2);
    localparam logic [DW-1:0]  DWELL_LIMIT = DW'(TIMEOUT);
    localparam logic [DW-1:0]  DWELL_MAX   = '1;
    localparam logic [2:0]     LAST        = 3'(STAGES);

    state_t            state, state_n;
    logic [STAGES-1:0] ena_q;
    logic [2:0]        stage_q, stage_n;
    logic [DW-1:0]     dwell_q, dwell_n;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [1:0]        code_q, code_n;
    logic              done_q, done_n;
    logic              busy_q, err_q;

    logic [2:0]        dec_stage;
    logic              dec_legal;
    logic              step_ok, hold_nz, timeout_hit;

    enable_stage_decoder #(.STAGES(STAGES)) u_dec (
        .ena   (ena_q),
        .stage (dec_stage),
        .legal (dec_legal)
    );

    // s+1 covers both 0->1 and the middle advances; only the last stage may
    // fall back to 0.
    assign step_ok = (dec_stage == stage_q)
                  || (stage_q != LAST && dec_stage == stage_q + 3'd1)
                  || (stage_q == LAST && dec_stage == 3'd0);
    assign hold_nz     = (dec_stage == stage_q) && (dec_stage != 3'd0);
    assign timeout_hit = (TIMEOUT != 0) && hold_nz && (dwell_q == DWELL_LIMIT);

    always_comb begin
        state_n = state;
        stage_n = stage_q;
        dwell_n = dwell_q;
        cnt_n   = cnt_q;
        code_n  = code_q;
        done_n  = 1'b0;
        case (state)
            IDLE, ACTIVE: begin
                if (!dec_legal) begin
                    state_n = ERROR;
                    code_n  = ERR_ILLEGAL;
                    dwell_n = '0;
                end else if (!step_ok) begin
                    state_n = ERROR;
                    code_n  = ERR_SKIP;
                    dwell_n = '0;
                end else if (timeout_hit) begin
                    state_n = ERROR;
                    code_n  = ERR_TIMEOUT;
                    dwell_n = '0;
                end else begin
                    stage_n = dec_stage;
                    state_n = (dec_stage == 3'd0) ? IDLE : ACTIVE;
                    if (hold_nz) begin
                        dwell_n = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;
                    end else begin
                        dwell_n = (dec_stage != 3'd0) ? DW'(1) : '0;
                    end
                    if (stage_q == LAST && dec_stage == 3'd0) begin
                        done_n = 1'b1;
                        cnt_n  = cnt_q + 1'b1;
                    end
                end
            end
            ERROR: begin
                if (bus.clr_err) begin
                    state_n = RESYNC;
                    code_n  = ERR_NONE;
                    stage_n = 3'd0;
                    dwell_n = '0;
                end
            end
            RESYNC: begin
                if (dec_legal && dec_stage == 3'd0) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ena_q   <= '0;
            stage_q <= 3'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= ERR_NONE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ena_q   <= bus.ena_in;
            stage_q <= stage_n;
            dwell_q <= dwell_n;
            cnt_q   <= cnt_n;
            code_q  <= code_n;
            done_q  <= done_n;
            busy_q  <= (state_n == ACTIVE);
            err_q   <= (state_n == ERROR);
        end
    end

    assign bus.stage_o  = stage_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
    assign bus.seq_cnt  = cnt_q;

endmodule
